mem_wb_pipe_reg: RTL and testbench

MEM_WB_PIPE_REG -- requirements
Module: mem_wb_pipe_reg

---
 rtl/mem_wb_pipe_reg.sv | 168 ++++++++++++++++
 tb/tb_mem_wb_pipe_reg.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB pipeline register with valid/ready handshake, write-back select and stall counter.
// Define MEM_WB_PIPE_REG_SKID_EN for a two-entry skid buffer with a registered in_ready.
module mem_wb_pipe_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEST_W = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wb_en,
    input  logic              in_mem_r_en,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_mem_read_value,
    input  logic [DEST_W-1:0] in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_wb_en,
    output logic              out_mem_r_en,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [DATA_W-1:0] out_mem_read_value,
    output logic [DEST_W-1:0] out_dest,
    output logic [DATA_W-1:0] out_wb_data,
    output logic              out_wb_commit,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic              wb_en;
        logic              mem_r_en;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] mem_read_value;
        logic [DEST_W-1:0] dest;
    } payload_t;

    payload_t               w_in_pl;
    payload_t               r_main;
    logic                   r_out_valid;
    logic [CNT_W-1:0]       r_stall_cnt;
    logic                   w_accept;
    logic                   w_consume;

    assign w_in_pl   = '{wb_en:          in_wb_en,
                         mem_r_en:       in_mem_r_en,
                         alu_result:     in_alu_result,
                         mem_read_value: in_mem_read_value,
                         dest:           in_dest};
    assign w_accept  = in_valid & in_ready;
    assign w_consume = r_out_valid & out_ready;

`ifdef MEM_WB_PIPE_REG_SKID_EN
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t   r_state;
    state_t   w_state_nxt;
    payload_t r_skid;
    logic     r_in_ready;
    logic     w_load_main;
    logic     w_load_skid;
    logic     w_skid_to_main;

    // State register; valid and ready are registered decodes of the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt != S_EMPTY);
            r_in_ready  <= (w_state_nxt != S_TWO);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: if (w_accept) w_state_nxt = S_ONE;
                S_ONE: begin
                    if (w_accept && !w_consume)      w_state_nxt = S_TWO;
                    else if (!w_accept && w_consume) w_state_nxt = S_EMPTY;
                end
                S_TWO:   if (w_consume) w_state_nxt = S_ONE;
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    // Datapath steering; accept is impossible in S_TWO since in_ready is low there
    always_comb begin
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
        if (!flush) begin
            case (r_state)
                S_EMPTY: w_load_main = w_accept;
                S_ONE: begin
                    w_load_main = w_accept & w_consume;
                    w_load_skid = w_accept & ~w_consume;
                end
                S_TWO:   w_skid_to_main = w_consume;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main)         r_main <= w_in_pl;
            else if (w_skid_to_main) r_main <= r_skid;
            if (w_load_skid)         r_skid <= w_in_pl;
        end
    end

    assign in_ready = r_in_ready;
`else
    // Single entry: a consume in the same cycle frees the slot for the incoming entry
    assign in_ready = ~r_out_valid | out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_main      <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_main      <= w_in_pl;
        end else if (w_consume) begin
            r_out_valid <= 1'b0;
        end
    end
`endif

    // Saturating stall counter, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (r_out_valid && !out_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign out_valid          = r_out_valid;
    assign out_wb_en          = r_main.wb_en;
    assign out_mem_r_en       = r_main.mem_r_en;
    assign out_alu_result     = r_main.alu_result;
    assign out_mem_read_value = r_main.mem_read_value;
    assign out_dest           = r_main.dest;
    assign stall_cnt          = r_stall_cnt;

    assign out_wb_data   = r_main.mem_r_en ? r_main.mem_read_value : r_main.alu_result;
    // Register 0 is hardwired, so writes to it never strobe the register file
    assign out_wb_commit = w_consume & r_main.wb_en & (r_main.dest != '0);

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Bench for mem_wb_pipe_reg: directed steps plus random traffic against a FIFO-queue model.
// Honours MEM_WB_PIPE_REG_SKID_EN to select one- or two-entry behaviour.
module tb_mem_wb_pipe_reg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEST_W = 5;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;
`ifdef MEM_WB_PIPE_REG_SKID_EN
    localparam int unsigned DEPTH = 2;
`else
    localparam int unsigned DEPTH = 1;
`endif

    typedef struct {
        logic        wb_en;
        logic        mem_r_en;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [4:0]  dest;
    } entry_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_wb_en = 1'b0;
    logic              in_mem_r_en = 1'b0;
    logic [DATA_W-1:0] in_alu_result = '0;
    logic [DATA_W-1:0] in_mem_read_value = '0;
    logic [DEST_W-1:0] in_dest = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_wb_en;
    logic              out_mem_r_en;
    logic [DATA_W-1:0] out_alu_result;
    logic [DATA_W-1:0] out_mem_read_value;
    logic [DEST_W-1:0] out_dest;
    logic [DATA_W-1:0] out_wb_data;
    logic              out_wb_commit;
    logic [CNT_W-1:0]  stall_cnt;

    entry_t      q[$];
    int unsigned m_stall = 0;
    int          n_total = 0;
    int          n_pass  = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    mem_wb_pipe_reg #(.DATA_W(DATA_W), .DEST_W(DEST_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_wb_en(in_wb_en), .in_mem_r_en(in_mem_r_en),
        .in_alu_result(in_alu_result), .in_mem_read_value(in_mem_read_value),
        .in_dest(in_dest),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_wb_en(out_wb_en), .out_mem_r_en(out_mem_r_en),
        .out_alu_result(out_alu_result), .out_mem_read_value(out_mem_read_value),
        .out_dest(out_dest), .out_wb_data(out_wb_data),
        .out_wb_commit(out_wb_commit), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Room for a new entry: a free slot, or (single entry) the held one leaving now
    function automatic bit exp_ready();
        if (DEPTH == 2) return q.size() < 2;
        return (q.size() == 0) || (out_ready == 1'b1);
    endfunction

    task automatic check_model();
        bit v;
        v = (q.size() != 0);
        chk("out_valid", 64'(out_valid), 64'(v));
        chk("in_ready",  64'(in_ready),  64'(exp_ready()));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        if (v) begin
            entry_t e;
            e = q[0];
            chk("out_wb_en",    64'(out_wb_en),          64'(e.wb_en));
            chk("out_mem_r_en", 64'(out_mem_r_en),       64'(e.mem_r_en));
            chk("out_alu",      64'(out_alu_result),     64'(e.alu));
            chk("out_mem",      64'(out_mem_read_value), 64'(e.mem));
            chk("out_dest",     64'(out_dest),           64'(e.dest));
            chk("wb_data",      64'(out_wb_data),        64'(e.mem_r_en ? e.mem : e.alu));
            chk("wb_commit",    64'(out_wb_commit),
                64'(out_ready && e.wb_en && (e.dest != 5'd0)));
        end else begin
            chk("wb_commit_idle", 64'(out_wb_commit), 64'(1'b0));
        end
    endtask

    task automatic model_update();
        bit     acc;
        bit     con;
        entry_t e;
        if (rst) begin
            q.delete();
            m_stall = 0;
            return;
        end
        acc = in_valid && exp_ready();
        con = (q.size() != 0) && out_ready;
        if ((q.size() != 0) && !out_ready && (m_stall < CNT_MAX)) m_stall++;
        if (flush) begin
            q.delete();
        end else begin
            if (con) void'(q.pop_front());
            if (acc) begin
                e.wb_en    = in_wb_en;
                e.mem_r_en = in_mem_r_en;
                e.alu      = in_alu_result;
                e.mem      = in_mem_read_value;
                e.dest     = in_dest;
                q.push_back(e);
            end
        end
    endtask

    task automatic set_in(input logic v, input logic wb, input logic mr,
                          input logic [31:0] alu, input logic [31:0] mem,
                          input logic [4:0] dest, input logic ordy, input logic fl);
        @(negedge clk);
        rst               = 1'b0;
        in_valid          = v;
        in_wb_en          = wb;
        in_mem_r_en       = mr;
        in_alu_result     = alu;
        in_mem_read_value = mem;
        in_dest           = dest;
        out_ready         = ordy;
        flush             = fl;
        #1;
        check_model();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
    endtask

    task automatic idle(input logic ordy);
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, ordy, 1'b0);
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid),          64'(1'b0));
        chk("rst_in_ready",  64'(in_ready),           64'(1'b1));
        chk("rst_stall",     64'(stall_cnt),          64'(0));
        chk("rst_alu",       64'(out_alu_result),     64'(0));
        chk("rst_mem",       64'(out_mem_read_value), 64'(0));
        chk("rst_dest",      64'(out_dest),           64'(0));
        chk("rst_wb_en",     64'(out_wb_en),          64'(1'b0));

        // Load entry selects memory data and commits
        set_in(1'b1, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 5'd8, 1'b1, 1'b0);
        tick();
        idle(1'b1);
        chk("load_wb_data", 64'(out_wb_data),   64'h0000_0000_DEAD_BEEF);
        chk("load_commit",  64'(out_wb_commit), 64'(1'b1));
        tick();

        // Write to register 0 is suppressed
        set_in(1'b1, 1'b1, 1'b0, 32'h5, 32'h0, 5'd0, 1'b1, 1'b0);
        tick();
        idle(1'b1);
        chk("r0_valid",  64'(out_valid),     64'(1'b1));
        chk("r0_commit", 64'(out_wb_commit), 64'(1'b0));
        tick();

        // Three stalled cycles hold the payload
        set_in(1'b1, 1'b1, 1'b0, 32'h1234_5678, 32'h0BAD_F00D, 5'd3, 1'b0, 1'b0);
        tick();
        repeat (3) begin
            set_in(1'b1, 1'b0, 1'b1, 32'hAAAA_0001, 32'h5555_0002, 5'd9, 1'b0, 1'b0);
            tick();
        end
        idle(1'b0);
        chk("stall_cnt3",  64'(stall_cnt),      64'(3));
        chk("stall_alu",   64'(out_alu_result), 64'h0000_0000_1234_5678);
        chk("stall_ready", 64'(in_ready),       64'(1'b0));
        tick();
        repeat (3) begin
            idle(1'b1);
            tick();
        end

        // Flush with a held entry and an incoming entry in the same cycle
        set_in(1'b1, 1'b0, 1'b0, 32'h7777, 32'h0, 5'd4, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 1'b1, 1'b0, 32'h8888, 32'h0, 5'd5, 1'b1, 1'b1);
        tick();
        idle(1'b1);
        chk("flush_valid", 64'(out_valid), 64'(1'b0));
        tick();
        idle(1'b1);
        chk("flush_gone", 64'(out_valid), 64'(1'b0));
        tick();

`ifdef MEM_WB_PIPE_REG_SKID_EN
        // Two entries buffered under backpressure drain in order
        set_in(1'b1, 1'b0, 1'b0, 32'hA, 32'h0, 5'd1, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 1'b0, 1'b0, 32'hB, 32'h0, 5'd2, 1'b0, 1'b0);
        tick();
        idle(1'b0);
        chk("skid_full_ready", 64'(in_ready), 64'(1'b0));
        tick();
        idle(1'b1);
        chk("skid_first", 64'(out_alu_result), 64'hA);
        tick();
        idle(1'b1);
        chk("skid_second", 64'(out_alu_result), 64'hB);
        tick();
        idle(1'b1);
        chk("skid_empty", 64'(out_valid), 64'(1'b0));
        tick();
`else
        // Back-to-back accept while consuming replaces with no bubble
        set_in(1'b1, 1'b0, 1'b0, 32'hC1, 32'h0, 5'd6, 1'b1, 1'b0);
        tick();
        set_in(1'b1, 1'b0, 1'b0, 32'hC2, 32'h0, 5'd7, 1'b1, 1'b0);
        chk("b2b_ready", 64'(in_ready), 64'(1'b1));
        tick();
        idle(1'b1);
        chk("b2b_second", 64'(out_alu_result), 64'hC2);
        tick();
`endif

        // Random traffic against the queue model
        repeat (400) begin
            set_in(1'($urandom_range(0, 99) < 60), 1'($urandom), 1'($urandom),
                   32'($urandom), 32'($urandom),
                   ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                   1'($urandom_range(0, 99) < 65), 1'($urandom_range(0, 15) == 0));
            tick();
        end

        // Stall counter saturates
        repeat (3) begin
            idle(1'b1);
            tick();
        end
        set_in(1'b1, 1'b1, 1'b0, 32'h51, 32'h0, 5'd10, 1'b0, 1'b0);
        tick();
        repeat (CNT_MAX + 4) begin
            idle(1'b0);
            tick();
        end
        idle(1'b0);
        chk("stall_sat", 64'(stall_cnt), 64'(CNT_MAX));

        // Async reset between edges clears at once
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 64'(out_valid),      64'(1'b0));
        chk("arst_stall", 64'(stall_cnt),      64'(0));
        chk("arst_ready", 64'(in_ready),       64'(1'b1));
        chk("arst_alu",   64'(out_alu_result), 64'(0));
        q.delete();
        m_stall = 0;
        tick();

        // First cycle after reset release accepts
        set_in(1'b1, 1'b1, 1'b1, 32'h99, 32'hFEED_0001, 5'd12, 1'b1, 1'b0);
        chk("post_rst_ready", 64'(in_ready), 64'(1'b1));
        tick();
        idle(1'b1);
        chk("post_rst_data", 64'(out_wb_data), 64'h0000_0000_FEED_0001);
        tick();
        idle(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
